fir_stream_if: RTL and testbench

- Streaming front/back end for the 5-phase FIR controller and datapath.
- Input side: accepts 8-bit samples on a valid/ready stream, buffers them, and presents one sample on `x` per filter frame.
- Output side: captures the filter result on `y` during the controller's final phase and emits it on a valid/ready output stream.
- Tracks the controller's phase from its strobes, detects sequencing errors, and reports underrun/overrun.

---
 rtl/fir_stream_if.sv | 231 +++++++++++++++++++++++
 tb/tb_fir_stream_if.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_if.sv
// fir_stream_if
//   Streaming front/back end for the 5-phase FIR controller.
//   - Input side: buffers upstream samples in a small FIFO and presents the
//     head sample on x for one whole filter frame.
//   - Output side: captures the controller result y in S5 and holds it on a
//     valid/ready output stream.
//   - Tracks the controller phase from its strobes and flags sequencing
//     errors, underrun (S5 with nothing to feed) and overrun (an unaccepted
//     result overwritten).
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   s_data/s_valid/s_ready   upstream sample stream
//   x0s, x10s           controller strobes (S1, S3)
//   y                   controller result, valid in S5
//   x                   sample presented to the controller
//   m_data/m_valid/m_ready   filtered output stream
//   locked              phase tracker locked
//   underrun, overrun, seq_err   sticky status, cleared only by reset
//
// Phase tracker states
//   state  | meaning
//   UNLOCK | waiting for x0s to mark S1; ph held at 0
//   LOCK   | ph counts S1..S5 (0..4); strobes checked every cycle

module fir_stream_if #(
    parameter int DW       = 8,
    parameter int IN_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          x0s,
    input  logic          x10s,
    input  logic [DW-1:0] y,
    output logic [DW-1:0] x,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          locked,
    output logic          underrun,
    output logic          overrun,
    output logic          seq_err
);

    localparam int AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(IN_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [2:0]    PH_S1   = 3'd0;
    localparam logic [2:0]    PH_S3   = 3'd2;
    localparam logic [2:0]    PH_S5   = 3'd4;

    typedef enum logic {
        UNLOCK = 1'b0,
        LOCK   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ph_q, ph_d;

    logic [DW-1:0] mem_q [IN_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          s_ready_q, s_ready_d;

    logic          pending_q, pending_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;

    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;
    logic          seq_err_q, seq_err_d;

    logic          check_ok;
    logic          seq_fail;
    logic          s5;
    logic          push;
    logic          pop;
    logic          emit;
    logic          fifo_nonempty;

    assign fifo_nonempty = (count_q != '0);
    assign push          = s_valid && s_ready_q;

    // Phase tracker and all frame-level decisions.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        seq_fail = 1'b0;
        s5       = 1'b0;
        check_ok = (x0s == (ph_q == PH_S1)) && (x10s == (ph_q == PH_S3));

        case (state_q)
            UNLOCK: begin
                if (x0s) begin
                    // This cycle is S1, so the next one is S2.
                    state_d = LOCK;
                    ph_d    = 3'd1;
                end else begin
                    ph_d = PH_S1;
                end
            end
            LOCK: begin
                if (!check_ok) begin
                    // The failing cycle is not reconsidered as an S1 candidate.
                    seq_fail = 1'b1;
                    state_d  = UNLOCK;
                    ph_d     = PH_S1;
                end else begin
                    s5   = (ph_q == PH_S5);
                    ph_d = (ph_q == PH_S5) ? PH_S1 : ph_q + 3'd1;
                end
            end
            default: begin
                state_d = UNLOCK;
                ph_d    = PH_S1;
            end
        endcase
    end

    assign pop  = s5 && fifo_nonempty;
    assign emit = s5 && pending_q;

    // Input FIFO bookkeeping.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        s_ready_d = (count_d != DEPTH_C);
    end

    // Output capture and sticky status.
    always_comb begin
        pending_d  = pending_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        seq_err_d  = seq_err_q;

        if (seq_fail) begin
            seq_err_d = 1'b1;
            pending_d = 1'b0;
        end else if (s5) begin
            // pending says whether the word the controller just filtered was a
            // real sample; it is refreshed at the end of every locked S5.
            pending_d = fifo_nonempty;
            if (!fifo_nonempty) begin
                underrun_d = 1'b1;
            end
        end

        if (emit) begin
            m_data_d  = y;
            m_valid_d = 1'b1;
            if (m_valid_q && !m_ready) begin
                overrun_d = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= UNLOCK;
            ph_q       <= PH_S1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            s_ready_q  <= 1'b1;
            pending_q  <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            s_ready_q  <= s_ready_d;
            pending_q  <= pending_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            seq_err_q  <= seq_err_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // Head only moves on a pop, so x is stable for the whole frame.
    assign x        = ((state_q == LOCK) && fifo_nonempty) ? mem_q[rd_ptr_q] : '0;
    assign s_ready  = s_ready_q;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign locked   = (state_q == LOCK);
    assign underrun = underrun_q;
    assign overrun  = overrun_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_fir_stream_if.sv
module tb_fir_stream_if;

    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          x0s;
    logic          x10s;
    logic [DW-1:0] y;
    logic [DW-1:0] x;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          locked;
    logic          underrun;
    logic          overrun;
    logic          seq_err;

    // Controller stub state
    logic          stub_en;
    logic [2:0]    stub_ph;
    logic [DW-1:0] lat_x;
    logic          inj10;

    int nvec = 0;
    int nerr = 0;

    fir_stream_if #(.DW(DW), .IN_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .x0s      (x0s),
        .x10s     (x10s),
        .y        (y),
        .x        (x),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .locked   (locked),
        .underrun (underrun),
        .overrun  (overrun),
        .seq_err  (seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: controller stub drives strobes and y = last latched x + 1,
    // and latches x at the end of its S5.
    task automatic cyc();
        logic [DW-1:0] xs;
        xs   = x;
        x0s  = stub_en && (stub_ph == 3'd0);
        x10s = (stub_en && (stub_ph == 3'd2)) || inj10;
        y    = lat_x + 8'd1;
        @(posedge clk);
        #1;
        if (stub_en) begin
            if (stub_ph == 3'd4) lat_x = xs;
            stub_ph = (stub_ph == 3'd4) ? 3'd0 : stub_ph + 3'd1;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        stub_en = 1'b0;
        stub_ph = 3'd0;
        lat_x   = '0;
        inj10   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        x0s     = 1'b0;
        x10s    = 1'b0;
        y       = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // ---------------- reset state
        reset   = 1'b0;
        stub_en = 1'b0;
        stub_ph = 3'd0;
        lat_x   = '0;
        inj10   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        x0s     = 1'b0;
        x10s    = 1'b0;
        y       = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_locked", locked, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_seq_err", seq_err, 0);
        reset = 1'b1;

        // ---------------- T1: lock and underrun with no input
        cyc();
        chk("t1_unlocked_idle", locked, 0);
        stub_en = 1'b1;
        cyc();                              // S1
        chk("t1_locked", locked, 1);
        cycles(3);                          // S2..S4
        chk("t1_no_underrun_yet", underrun, 0);
        cyc();                              // S5 with empty FIFO
        chk("t1_underrun", underrun, 1);
        chk("t1_m_valid", m_valid, 0);
        cycles(5);
        chk("t1_m_valid_later", m_valid, 0);

        // ---------------- T2: samples 5, 9, 200 -> 6, 10, 201
        do_reset();
        stub_en = 1'b1;
        s_valid = 1'b1; s_data = 8'd5;
        cyc();                              // S1, push 5
        chk("t2_locked", locked, 1);
        chk("t2_x_head", x, 5);
        s_data = 8'd9;
        cyc();                              // S2, push 9
        s_data = 8'd200;
        cyc();                              // S3, push 200
        s_valid = 1'b0;
        cycles(2);                          // S4, S5: pop 5
        chk("t2_x_after_pop1", x, 9);
        chk("t2_no_emit_f1", m_valid, 0);
        cycles(4);
        chk("t2_not_valid_before", m_valid, 0);
        cyc();                              // S5: emit 6, pop 9
        chk("t2_valid1", m_valid, 1);
        chk("t2_data1", m_data, 6);
        chk("t2_x_after_pop2", x, 200);
        cyc();
        chk("t2_valid1_clear", m_valid, 0);
        cycles(4);                          // S5: emit 10, pop 200
        chk("t2_valid2", m_valid, 1);
        chk("t2_data2", m_data, 10);
        chk("t2_x_empty", x, 0);
        chk("t2_no_underrun", underrun, 0);
        cycles(5);                          // S5: emit 201, FIFO empty
        chk("t2_valid3", m_valid, 1);
        chk("t2_data3", m_data, 201);
        chk("t2_underrun_after_drain", underrun, 1);

        // ---------------- T3: fill FIFO while unlocked
        do_reset();
        s_valid = 1'b1;
        s_data = 8'd11; cyc();
        s_data = 8'd22; cyc();
        s_data = 8'd33; cyc();
        chk("t3_ready_3", s_ready, 1);
        s_data = 8'd44; cyc();
        chk("t3_ready_full", s_ready, 0);
        chk("t3_x_unlocked", x, 0);
        s_data = 8'd55;
        cycles(2);
        chk("t3_ready_held", s_ready, 0);
        stub_en = 1'b1;
        cyc();                              // S1
        chk("t3_x_locked_head", x, 11);
        cycles(3);
        chk("t3_ready_before_pop", s_ready, 0);
        cyc();                              // S5: pop 11
        chk("t3_ready_after_pop", s_ready, 1);
        chk("t3_x_next", x, 22);
        cyc();                              // 55 pushed
        chk("t3_ready_refull", s_ready, 0);
        s_valid = 1'b0;

        // ---------------- T4: overrun with m_ready low
        do_reset();
        m_ready = 1'b0;
        stub_en = 1'b1;
        s_valid = 1'b1; s_data = 8'd5;
        cyc();
        s_data = 8'd9;
        cyc();
        s_valid = 1'b0;
        cycles(3);                          // S5 frame 1: pop 5
        cycles(5);                          // S5 frame 2: emit 6
        chk("t4_valid1", m_valid, 1);
        chk("t4_data1", m_data, 6);
        chk("t4_no_overrun", overrun, 0);
        cycles(5);                          // S5 frame 3: emit 10 over unaccepted 6
        chk("t4_overrun", overrun, 1);
        chk("t4_data2", m_data, 10);
        chk("t4_valid2", m_valid, 1);
        m_ready = 1'b1;
        cyc();
        chk("t4_drained", m_valid, 0);
        chk("t4_overrun_sticky", overrun, 1);

        // ---------------- T5: sequencing error at ph=3, then at ph=4
        cycles(2);                          // stub now at S4 (ph=3)
        inj10 = 1'b1;
        cyc();
        inj10 = 1'b0;
        chk("t5_seq_err", seq_err, 1);
        chk("t5_unlocked", locked, 0);
        chk("t5_no_emit", m_valid, 0);
        cyc();
        chk("t5_still_unlocked", locked, 0);
        cyc();                              // x0s relocks
        chk("t5_relocked", locked, 1);
        s_valid = 1'b1; s_data = 8'd77;
        cyc();
        s_valid = 1'b0;
        chk("t5_x_77", x, 77);
        cycles(2);                          // stub now at S5 (ph=4)
        inj10 = 1'b1;
        cyc();
        inj10 = 1'b0;
        chk("t5_unlocked_s5", locked, 0);
        chk("t5_x_zero_unlocked", x, 0);
        chk("t5_no_emit_s5", m_valid, 0);
        cyc();                              // relock
        chk("t5_relocked2", locked, 1);
        chk("t5_no_pop", x, 77);

        // ---------------- T6: async reset mid-frame with 3 entries
        do_reset();
        chk("t6_seq_err_cleared", seq_err, 0);
        s_valid = 1'b1; s_data = 8'd1;
        cyc();
        stub_en = 1'b1;
        s_data = 8'd2;
        cyc();
        s_data = 8'd3;
        cyc();
        s_valid = 1'b0;
        chk("t6_pre_locked", locked, 1);
        chk("t6_pre_x", x, 1);
        reset = 1'b0;
        #2;
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_x", x, 0);
        chk("t6_rst_s_ready", s_ready, 1);
        chk("t6_rst_m_valid", m_valid, 0);
        chk("t6_rst_underrun", underrun, 0);
        stub_en = 1'b0;
        stub_ph = 3'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("t6_post_s_ready", s_ready, 1);
        stub_en = 1'b1;
        cyc();
        chk("t6_relock_x_empty", x, 0);
        cycles(4);
        chk("t6_fifo_was_empty", underrun, 1);
        chk("t6_m_valid", m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
